encoder_eight_drain: RTL and testbench

ENCODER_EIGHT_DRAIN -- requirements
Module: encoder_eight_drain

---
 rtl/encoder_eight_drain_pkg.sv | 20 ++
 rtl/encoder_eight_drain_prio_find.sv | 43 ++++
 rtl/encoder_eight_drain.sv | 113 +++++++++++
 tb/tb_encoder_eight_drain.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_eight_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_eight_drain_pkg
//  Description : Shared types and constants for the eight-line draining
//                priority encoder (state encoding, vector and index widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package encoder_eight_drain_pkg;

    localparam int IN_W  = 8;   // request vector width
    localparam int IDX_W = 3;   // binary index width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ZERO  = 2'd2
    } state_e;

endpackage : encoder_eight_drain_pkg
`default_nettype wire

// File: rtl/encoder_eight_drain_prio_find.sv
`default_nettype none
// ============================================================================
//  Module      : prio_find_eight
//  Description : Combinational priority finder over an 8-bit vector.
//                Returns the index of the lowest (lsb_first_i=1) or highest
//                (lsb_first_i=0) set bit, and flags a vector with exactly
//                one set bit.
//  Ports       : pending_i   - vector to search
//                lsb_first_i - search direction
//                index_o     - selected bit index (0 when vector is empty)
//                single_o    - vector has exactly one bit set
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_find_eight
    import encoder_eight_drain_pkg::*;
(
    input  logic [IN_W-1:0]  pending_i,
    input  logic             lsb_first_i,
    output logic [IDX_W-1:0] index_o,
    output logic             single_o
);

    // Later loop iterations overwrite earlier ones, so the scan runs from the
    // low-priority end toward the high-priority end.
    always_comb begin
        index_o = '0;
        if (lsb_first_i) begin
            for (int i = IN_W - 1; i >= 0; i--) begin
                if (pending_i[i]) index_o = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (pending_i[i]) index_o = IDX_W'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit; zero result means at most one bit.
    assign single_o = (pending_i != '0) &&
                      ((pending_i & (pending_i - IN_W'(1))) == '0);

endmodule : prio_find_eight
`default_nettype wire

// File: rtl/encoder_eight_drain.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_eight_drain
//  Description : Accepts a multi-hot 8-bit request vector and drains it one
//                set bit per output beat as a binary index, in LSB-first or
//                MSB-first order. An all-zero vector yields a single beat
//                flagged with out_zero.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                in_valid/in_ready/X   - request vector input handshake
//                out_valid/out_ready/Y - index output handshake
//                out_last              - final beat of the current vector
//                out_zero              - current beat reports an empty vector
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_eight_drain
    import encoder_eight_drain_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  X,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] Y,
    output logic             out_last,
    output logic             out_zero
);

    localparam logic c_LSB_FIRST = (LSB_FIRST != 0);

    state_e            state_q, state_d;
    logic [IN_W-1:0]   pending_q, pending_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [IDX_W-1:0]  y_q;
    logic              out_last_q;
    logic              out_zero_q;

    logic [IDX_W-1:0]  w_idx;
    logic              w_single;

    // Next-state: outside IDLE the input side is ignored entirely. A DRAIN
    // state always has out_valid_q set, so out_ready alone marks a handshake.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (X != '0) begin
                        pending_d = X;
                        state_d   = DRAIN;
                    end else begin
                        state_d   = ZERO;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    pending_d = pending_q & ~(IN_W'(1) << y_q);
                    if (out_last_q) state_d = IDLE;
                end
            end
            ZERO: begin
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // Searching the next pending vector lets every output be a flop while
    // still presenting the first beat on the edge after acceptance.
    prio_find_eight u_prio (
        .pending_i   (pending_d),
        .lsb_first_i (c_LSB_FIRST),
        .index_o     (w_idx),
        .single_o    (w_single)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            out_last_q  <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d != IDLE);
            y_q         <= (state_d == DRAIN) ? w_idx : '0;
            out_last_q  <= ((state_d == DRAIN) && w_single) || (state_d == ZERO);
            out_zero_q  <= (state_d == ZERO);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Y         = y_q;
    assign out_last  = out_last_q;
    assign out_zero  = out_zero_q;

endmodule : encoder_eight_drain
`default_nettype wire

// File: tb/tb_encoder_eight_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_eight_drain
//  Description : Scoreboard bench for encoder_eight_drain. Instance 0 drains
//                LSB-first, instance 1 MSB-first; X and out_ready are shared,
//                only one instance is active at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_eight_drain;

    typedef struct {
        int         dut;
        logic [2:0] y;
        logic       last;
        logic       zero;
    } beat_t;

    typedef struct {
        logic [7:0] x;
        int         n;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] x;
    logic       out_ready;
    logic       iv   [2];
    logic       ir   [2];
    logic       ov   [2];
    logic [2:0] yv   [2];
    logic       lst  [2];
    logic       zro  [2];

    beat_t sb[$];
    vec_t  vq[$];
    int    tests = 0;
    int    fails = 0;
    int    beat_cnt = 0;
    int    rdy_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random

    for (genvar g = 0; g < 2; g++) begin : g_dut
        encoder_eight_drain #(.LSB_FIRST(g == 0 ? 1 : 0)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .X         (x),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .Y         (yv[g]),
            .out_last  (lst[g]),
            .out_zero  (zro[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer ready driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic exp_beat(input int d, input int y, input bit last, input bit zero);
        beat_t b;
        b.dut = d; b.y = 3'(y); b.last = last; b.zero = zero;
        sb.push_back(b);
    endtask

    task automatic exp_vec(input logic [7:0] xv, input int n);
        vec_t v;
        v.x = xv; v.n = n;
        vq.push_back(v);
    endtask

    // Reference ordering: walk the bits in the instance's drain order.
    task automatic exp_model(input int d, input logic [7:0] xv);
        int cnt;
        int k;
        int b;
        if (xv == 8'h00) begin
            exp_beat(d, 0, 1'b1, 1'b1);
            exp_vec(xv, 1);
        end else begin
            cnt = $countones(xv);
            k   = 0;
            for (int i = 0; i < 8; i++) begin
                b = (d == 0) ? i : 7 - i;
                if (xv[b]) begin
                    k++;
                    exp_beat(d, b, k == cnt, 1'b0);
                end
            end
            exp_vec(xv, cnt);
        end
    endtask

    task automatic send(input int d, input logic [7:0] xv);
        int n = 0;
        @(posedge clk); #1;
        while (!ir[d] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ir[d]) begin
            tests++; fails++;
            $display("FAIL in_ready_timeout dut%0d: got 0 expected 1", d);
        end else begin
            iv[d] = 1'b1;
            x     = xv;
            @(posedge clk); #1;
            iv[d] = 1'b0;
            x     = $urandom;   // garbage outside IDLE must be ignored
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || vq.size() != 0) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        tests++;
        if (sb.size() != 0 || vq.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", sb.size());
            sb.delete();
            vq.delete();
        end
    endtask

    // Monitor: pops one expected beat per observed handshake, and checks the
    // per-vector beat count, one-hot subset and OR coverage on the last beat.
    logic [7:0] acc_or = '0;
    int         acc_n  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_or = '0;
            acc_n  = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (ov[d] && out_ready) begin
                    beat_t      e;
                    vec_t       v;
                    logic [7:0] oh;
                    beat_cnt++;
                    oh = 8'd1 << yv[d];
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_beat dut%0d: got Y=%0d expected no beat", d, yv[d]);
                    end else begin
                        e = sb.pop_front();
                        if (e.dut != d || yv[d] != e.y || lst[d] != e.last || zro[d] != e.zero) begin
                            fails++;
                            $display("FAIL beat dut%0d: got Y=%0d last=%0b zero=%0b expected dut%0d Y=%0d last=%0b zero=%0b",
                                     d, yv[d], lst[d], zro[d], e.dut, e.y, e.last, e.zero);
                        end
                    end
                    if (!zro[d]) begin
                        if (vq.size() != 0) begin
                            tests++;
                            if ((oh & vq[0].x) != oh) begin
                                fails++;
                                $display("FAIL subset: got Y=%0d expected a bit of X=%02h", yv[d], vq[0].x);
                            end
                        end
                        acc_or = acc_or | oh;
                    end
                    acc_n++;
                    if (lst[d]) begin
                        tests++;
                        if (vq.size() == 0) begin
                            fails++;
                            $display("FAIL unexpected_last dut%0d: got last=1 expected no vector", d);
                        end else begin
                            v = vq.pop_front();
                            if (acc_or != v.x || acc_n != v.n) begin
                                fails++;
                                $display("FAIL vector: got OR=%02h beats=%0d expected OR=%02h beats=%0d",
                                         acc_or, acc_n, v.x, v.n);
                            end
                        end
                        acc_or = '0;
                        acc_n  = 0;
                    end
                end
            end
        end
    end

    initial begin
        int start;
        int n;
        rst_n = 1'b0;
        x     = '0;
        iv[0] = 1'b0;
        iv[1] = 1'b0;

        // Reset state, held across clock edges.
        #22;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready",  int'(ir[d]),  0);
            chk("rst_out_valid", int'(ov[d]),  0);
            chk("rst_Y",         int'(yv[d]),  0);
            chk("rst_last",      int'(lst[d]), 0);
            chk("rst_zero",      int'(zro[d]), 0);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready0", int'(ir[0]), 1);
        chk("post_rst_in_ready1", int'(ir[1]), 1);

        // LSB-first 1010_0100 -> 2, 5, 7.
        rdy_mode = 1;
        exp_beat(0, 2, 1'b0, 1'b0);
        exp_beat(0, 5, 1'b0, 1'b0);
        exp_beat(0, 7, 1'b1, 1'b0);
        exp_vec(8'b1010_0100, 3);
        send(0, 8'b1010_0100);
        chk("first_beat_valid", int'(ov[0]), 1);
        chk("busy_in_ready", int'(ir[0]), 0);
        wait_idle();
        @(posedge clk); #1;
        chk("lsb_in_ready_after", int'(ir[0]), 1);

        // MSB-first FF -> 7 down to 0.
        exp_model(1, 8'hFF);
        send(1, 8'hFF);
        wait_idle();
        @(posedge clk); #1;
        chk("msb_in_ready_after", int'(ir[1]), 1);

        // All-zero vector on both orders.
        exp_beat(0, 0, 1'b1, 1'b1);
        exp_vec(8'h00, 1);
        send(0, 8'h00);
        wait_idle();
        exp_beat(1, 0, 1'b1, 1'b1);
        exp_vec(8'h00, 1);
        send(1, 8'h00);
        wait_idle();

        // Back-pressure: 81 held for 5 cycles, then 0 and 7.
        rdy_mode = 0;
        exp_beat(0, 0, 1'b0, 1'b0);
        exp_beat(0, 7, 1'b1, 1'b0);
        exp_vec(8'h81, 2);
        send(0, 8'h81);
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", int'(ov[0]), 1);
            chk("stall_Y", int'(yv[0]), 0);
            chk("stall_last", int'(lst[0]), 0);
            @(posedge clk); #1;
        end
        rdy_mode = 1;
        wait_idle();

        // Reset after the second beat of 0F.
        exp_model(0, 8'h0F);
        start = beat_cnt;
        send(0, 8'h0F);
        n = 0;
        while (beat_cnt < start + 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("two_beats_before_rst", beat_cnt - start, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(ov[0]), 0);
        chk("mid_rst_in_ready", int'(ir[0]), 0);
        chk("residual_expected", sb.size(), 2);
        sb.delete();
        vq.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_mid_rst_in_ready", int'(ir[0]), 1);
        for (int c = 0; c < 10; c++) begin
            chk("no_residual_beat", int'(ov[0]), 0);
            @(posedge clk); #1;
        end

        // Random vectors with random consumer back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] rv;
            int d;
            d  = i % 2;
            rv = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            exp_model(d, rv);
            send(d, rv);
            wait_idle();
        end

        rdy_mode = 1;
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_encoder_eight_drain
`default_nettype wire
